// File: rtl/iter_multiplier_if.sv
//------------------------------------------------------------------------------
// Module      : iter_multiplier_if
// Description : Request/response handshake bundle for the iterative multiplier.
//               Carries the flush control, the request channel (valid/ready,
//               op, operands) and the response channel (valid/ready, result).
//   master : drives flush, req_valid, req_op, req_a, req_b, resp_ready
//   slave  : drives req_ready, resp_valid, resp_result
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface iter_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;

  modport master (
    output flush,
    output req_valid,
    output req_op,
    output req_a,
    output req_b,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_result
  );

  modport slave (
    input  flush,
    input  req_valid,
    input  req_op,
    input  req_a,
    input  req_b,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_result
  );
endinterface

`default_nettype wire

// File: rtl/iter_multiplier.sv
//------------------------------------------------------------------------------
// Module      : iter_multiplier
// Description : Iterative RV32M-style multiplier (MUL/MULH/MULHSU/MULHU).
//               Operands are converted to magnitudes on accept, the magnitude
//               product is built RADIX_BITS multiplier bits per cycle, and the
//               sign is applied to the full double-width product at the end.
//               Zero operands short-circuit straight to the response state.
// Ports       :
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-low reset (0 = reset)
//   bus  slave modport of iter_multiplier_if (flush, req_*, resp_*)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iter_multiplier #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input wire logic          clk,
  input wire logic          rst,
  iter_multiplier_if.slave  bus
);

  localparam int C_NITER = WIDTH / RADIX_BITS;
  localparam int C_CNT_W = (C_NITER > 1) ? $clog2(C_NITER) : 1;
  localparam int C_SH_W  = $clog2(2 * WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_NITER - 1);

  generate
    if ((WIDTH % RADIX_BITS) != 0) begin : g_bad_radix
      $error("iter_multiplier: RADIX_BITS must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_neg;
  logic [1:0]           r_op;
  logic                 r_resp_valid;
  logic [WIDTH-1:0]     r_resp_result;

  logic                 w_accept;
  logic                 w_zero;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_abs;
  logic [WIDTH-1:0]     w_b_abs;
  logic [C_SH_W-1:0]    w_shamt;
  logic [2*WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_final;

  // rst is folded in so the unit never advertises readiness while held in reset.
  assign bus.req_ready   = rst & (r_state == S_IDLE) & ~bus.flush;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_result = r_resp_result;

  assign w_accept = bus.req_valid & bus.req_ready;
  assign w_zero   = (bus.req_a == '0) | (bus.req_b == '0);

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH.
  assign w_a_neg = ((bus.req_op == 2'b01) | (bus.req_op == 2'b10)) & bus.req_a[WIDTH-1];
  assign w_b_neg = (bus.req_op == 2'b01) & bus.req_b[WIDTH-1];

  // WIDTH-bit negation of the most negative value yields 2^(WIDTH-1), which is
  // exactly the required magnitude when read as unsigned.
  assign w_a_abs = w_a_neg ? -bus.req_a : bus.req_a;
  assign w_b_abs = w_b_neg ? -bus.req_b : bus.req_b;

  // Partial product of one multiplier digit, placed at its digit position.
  assign w_shamt    = C_SH_W'(r_cnt) * C_SH_W'(RADIX_BITS);
  assign w_pp       = ((2*WIDTH)'(r_mcand) * (2*WIDTH)'(r_mplier[RADIX_BITS-1:0])) << w_shamt;
  assign w_acc_next = r_acc + w_pp;

  // Sign is applied once to the complete magnitude product.
  assign w_prod  = r_neg ? -w_acc_next : w_acc_next;
  assign w_final = (r_op == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_neg         <= 1'b0;
      r_op          <= 2'b00;
      r_resp_valid  <= 1'b0;
      r_resp_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= w_a_abs;
            r_mplier <= w_b_abs;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_op     <= bus.req_op;
            r_acc    <= '0;
            r_cnt    <= '0;
            if (w_zero) begin
              r_state       <= S_DONE;
              r_resp_valid  <= 1'b1;
              r_resp_result <= '0;
            end else begin
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> RADIX_BITS;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
              r_state       <= S_DONE;
              r_resp_valid  <= 1'b1;
              r_resp_result <= w_final;
            end
          end
        end

        S_DONE: begin
          // Flush and a completing handshake both retire the result; flush
          // simply wins so the response is never counted as delivered.
          if (bus.flush || bus.resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  a_valid_only_in_done: assert property (@(posedge clk) disable iff (!rst)
    r_resp_valid == (r_state == S_DONE));

  a_no_ready_when_busy: assert property (@(posedge clk) disable iff (!rst)
    (r_state != S_IDLE) |-> !bus.req_ready);

endmodule

`default_nettype wire

// File: tb/tb_iter_multiplier.sv
//------------------------------------------------------------------------------
// Module      : tb_iter_multiplier
// Description : Self-checking bench for iter_multiplier. A table of RV32M
//               vectors and random operations feed a scoreboard queue that a
//               response monitor drains; directed sequences cover latency,
//               early-out, flush, backpressure and reset; two extra instances
//               with RADIX_BITS 1 and 4 run against a reference model.
// Ports       : none
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_iter_multiplier;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sweep_go = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  iter_multiplier_if #(.WIDTH(W)) bus ();

  iter_multiplier #(.WIDTH(W), .RADIX_BITS(2)) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Independent signed-arithmetic reference for the four ops.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] ea;
    logic signed [65:0] eb;
    logic signed [65:0] p;
    ea = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    eb = (op == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Response monitor: every completed handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready && !bus.flush) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got 0x%08h with empty scoreboard", bus.resp_result);
      end else begin
        mon_exp = sb.pop_front();
        check("scoreboard", bus.resp_result, mon_exp);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit track, input logic [31:0] exp);
    int n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: req_ready=0 required 1");
    end else if (track) begin
      sb.push_back(exp);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom_range(0, 3));
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
  endtask

  // Cycles from the accept edge to the first resp_valid cycle; returns at negedge.
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!bus.resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // RADIX_BITS sweep: each instance runs after the previous one finishes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int R   = (gi == 0) ? 1 : 4;
    localparam int LAT = W / R + 1;

    iter_multiplier_if #(.WIDTH(W)) sbus ();

    iter_multiplier #(.WIDTH(W), .RADIX_BITS(R)) u_dut (
      .clk (clk),
      .rst (rst_n),
      .bus (sbus.slave)
    );

    logic done = 1'b0;

    initial begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          n;
      sbus.flush      = 1'b0;
      sbus.req_valid  = 1'b0;
      sbus.req_op     = 2'b00;
      sbus.req_a      = '0;
      sbus.req_b      = '0;
      sbus.resp_ready = 1'b1;
      if (gi == 0) wait (sweep_go);
      else         wait (g_sweep[0].done);
      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) begin
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        b  = $urandom;
        if (i == 0) begin op = 2'b11; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        if (i == 1) begin op = 2'b01; a = 32'h8000_0000; b = 32'h8000_0000; end
        if (i == 2) begin op = 2'b10; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        if (i == 3) b = 32'h0;
        exp = ref_mul(op, a, b);
        sbus.req_valid = 1'b1;
        sbus.req_op    = op;
        sbus.req_a     = a;
        sbus.req_b     = b;
        n = 0;
        @(negedge clk);
        while (!sbus.req_ready && n < 100) begin
          @(negedge clk);
          n++;
        end
        check($sformatf("sweep_r%0d_ready_%0d", R, i), 32'(sbus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        sbus.req_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!sbus.resp_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        check($sformatf("sweep_r%0d_valid_%0d", R, i), 32'(sbus.resp_valid), 32'd1);
        check($sformatf("sweep_r%0d_result_%0d", R, i), sbus.resp_result, exp);
        if (i == 0) check($sformatf("sweep_r%0d_latency", R), 32'(n), 32'(LAT));
        if (i == 3) check($sformatf("sweep_r%0d_early_latency", R), 32'(n), 32'd1);
        @(posedge clk);
        #1;
      end
      done = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int bad_stable;
    int bad_ready;
    int n;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[2]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[3]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
    vecs[4]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[5]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[6]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB};
    vecs[7]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[8]  = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
    vecs[9]  = '{2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[10] = '{2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000};
    vecs[11] = '{2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_result", bus.resp_result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Full-length latency
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    wait_valid(lat);
    check("latency_full", 32'(lat), 32'd17);
    @(posedge clk);
    #1;

    // Zero-operand early-out
    issue(2'b00, 32'h0, 32'h0000_1234, 1'b1, 32'h0);
    wait_valid(lat);
    check("latency_early_out", 32'(lat), 32'd1);
    @(posedge clk);
    #1;

    // Vector table, back to back
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp);
    end
    drain();

    // Flush during CALC cycle 5
    issue(2'b00, 32'd123, 32'd456, 1'b0, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_calc_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    check("flush_no_resp", 32'(seen), 32'd0);
    check("flush_back_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    issue(2'b00, 32'd6, 32'd7, 1'b1, 32'd42);
    drain();

    // Flush in IDLE blocks acceptance
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 32'd5;
    bus.req_b     = 32'd5;
    @(negedge clk);
    check("flush_idle_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_not_taken", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Flush while the result waits in DONE
    bus.resp_ready = 1'b0;
    issue(2'b01, 32'd5, 32'd9, 1'b0, 32'h0);
    wait_valid(lat);
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_done_valid", 32'(bus.resp_valid), 32'd0);
    check("flush_done_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Backpressure: result held for 10 cycles
    issue(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 32'hFFFF_FFFF);
    wait_valid(lat);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bad_stable = 0;
    bad_ready  = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.resp_result !== 32'hFFFF_FFFF) bad_stable++;
      if (bus.req_ready) bad_ready++;
    end
    check("backpressure_stable", 32'(bad_stable), 32'd0);
    check("backpressure_req_ready", 32'(bad_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    drain();

    // Asynchronous reset in the middle of CALC
    issue(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("async_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("async_rst_resp_result", bus.resp_result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(2'b00, 32'd6, 32'd7, 1'b1, 32'd42);
    drain();

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (i % 8 == 5) a = 32'h0;
      if (i % 8 == 6) a = 32'h8000_0000;
      issue(op, a, b, 1'b1, ref_mul(op, a, b));
    end
    drain();

    // RADIX_BITS sweep instances
    sweep_go = 1'b1;
    n = 0;
    while (!g_sweep[1].done && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("sweep_complete", 32'(g_sweep[1].done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
